// File: rtl/mux_4_to_1_pkg.sv
// Shared constants and types for the mux_4_to_1 lane selector.
// Optional change-pulse output is enabled by MUX_4_TO_1_CHG_EN.
package mux_4_to_1_pkg;

  localparam int N_IN  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;

  function automatic logic [N_IN-1:0] sel_onehot(
    input sel_t s
  );
    logic [N_IN-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux_4_to_1_if.sv
// Bus bundle for mux_4_to_1: lane inputs, select, enable and outputs.
// The chg signal exists only when MUX_4_TO_1_CHG_EN is defined.
interface mux_4_to_1_if
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [N_IN*WIDTH-1:0] din;
  sel_t                  sel;
  logic                  en;
  logic [WIDTH-1:0]      z;
  logic [WIDTH-1:0]      z_q;
  sel_t                  sel_q;
`ifdef MUX_4_TO_1_CHG_EN
  logic                  chg;
`endif

`ifdef MUX_4_TO_1_CHG_EN
  modport master (
    output din, sel, en,
    input  z, z_q, sel_q, chg
  );

  modport slave (
    input  din, sel, en,
    output z, z_q, sel_q, chg
  );
`else
  modport master (
    output din, sel, en,
    input  z, z_q, sel_q
  );

  modport slave (
    input  din, sel, en,
    output z, z_q, sel_q
  );
`endif

endinterface

// File: rtl/mux_4_to_1_core.sv
// Combinational one-of-four lane selector, WIDTH bits per lane.
// Unaffected by MUX_4_TO_1_CHG_EN.
module mux_4_to_1_core
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [N_IN*WIDTH-1:0] i_din,
  input  sel_t                  i_sel,
  output logic [WIDTH-1:0]      o_z
);

  logic [N_IN-1:0] w_hot;

  assign w_hot = sel_onehot(i_sel);

  always_comb begin
    o_z = '0;
    unique case (1'b1)
      w_hot[0]: o_z = i_din[0*WIDTH +: WIDTH];
      w_hot[1]: o_z = i_din[1*WIDTH +: WIDTH];
      w_hot[2]: o_z = i_din[2*WIDTH +: WIDTH];
      w_hot[3]: o_z = i_din[3*WIDTH +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux_4_to_1.sv
// Lane selector with combinational z and enable-gated registered z_q/sel_q.
// Define MUX_4_TO_1_CHG_EN to add the registered chg change pulse.
module mux_4_to_1
  import mux_4_to_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  mux_4_to_1_if.slave bus
);

  logic [WIDTH-1:0] w_z;
  logic [WIDTH-1:0] r_z_q;
  sel_t             r_sel_q;

  mux_4_to_1_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_din (bus.din),
    .i_sel (bus.sel),
    .o_z   (w_z)
  );

  assign bus.z     = w_z;
  assign bus.z_q   = r_z_q;
  assign bus.sel_q = r_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_z_q   <= '0;
      r_sel_q <= '0;
    end else if (bus.en) begin
      r_z_q   <= w_z;
      r_sel_q <= bus.sel;
    end
  end

`ifdef MUX_4_TO_1_CHG_EN
  logic r_chg;

  // Pulse only on enabled loads; compare against the value being replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chg <= 1'b0;
    end else if (bus.en) begin
      r_chg <= (w_z != r_z_q);
    end else begin
      r_chg <= 1'b0;
    end
  end

  assign bus.chg = r_chg;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// Directed self-checking bench for mux_4_to_1 at WIDTH=1 and WIDTH=8.
// Define MUX_4_TO_1_CHG_EN to also check the chg pulse.
module tb_mux_4_to_1;

  logic clk;
  logic rst;
  int   passes;
  int   total;

  mux_4_to_1_if #(.WIDTH(1)) bus1 ();
  mux_4_to_1_if #(.WIDTH(8)) bus8 ();

  mux_4_to_1 #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp holds {z@sel3, z@sel2, z@sel1, z@sel0}
  task automatic comb1(
    input logic [3:0] d,
    input logic [3:0] exp
  );
    bus1.din = d;
    for (int i = 0; i < 4; i++) begin
      bus1.sel = 2'(i);
      #1;
      check($sformatf("z1 din=%h sel=%0d", d, i),
            32'(bus1.z), 32'(exp[i]));
    end
  endtask

  task automatic chk_chg(
    input string tag,
    input logic  exp
  );
`ifdef MUX_4_TO_1_CHG_EN
    check(tag, 32'(bus1.chg), 32'(exp));
`endif
  endtask

  initial begin
    passes   = 0;
    total    = 0;
    rst      = 1'b1;
    bus1.din = '0;
    bus1.sel = '0;
    bus1.en  = 1'b0;
    bus8.din = '0;
    bus8.sel = '0;
    bus8.en  = 1'b0;

    tick();
    tick();
    check("rst z_q1",   32'(bus1.z_q),   32'h0);
    check("rst sel_q1", 32'(bus1.sel_q), 32'h0);
    check("rst z_q8",   32'(bus8.z_q),   32'h0);
    check("rst sel_q8", 32'(bus8.sel_q), 32'h0);
    chk_chg("rst chg", 1'b0);

    comb1(4'hb, 4'b1011);
    comb1(4'h3, 4'b0011);
    comb1(4'hf, 4'b1111);
    comb1(4'h6, 4'b0110);

    bus8.din = 32'hDDCCBBAA;
    bus8.sel = 2'd0; #1;
    check("z8 sel0", 32'(bus8.z), 32'hAA);
    bus8.sel = 2'd1; #1;
    check("z8 sel1", 32'(bus8.z), 32'hBB);
    bus8.sel = 2'd2; #1;
    check("z8 sel2", 32'(bus8.z), 32'hCC);
    bus8.sel = 2'd3; #1;
    check("z8 sel3", 32'(bus8.z), 32'hDD);

    rst      = 1'b0;
    bus1.en  = 1'b1;
    bus1.din = 4'hb;
    bus1.sel = 2'd2;
    bus8.en  = 1'b1;
    bus8.sel = 2'd1;
    tick();
    check("load z_q1",   32'(bus1.z_q),   32'h0);
    check("load sel_q1", 32'(bus1.sel_q), 32'h2);
    check("load z_q8",   32'(bus8.z_q),   32'hBB);
    check("load sel_q8", 32'(bus8.sel_q), 32'h1);
    chk_chg("same-0 chg", 1'b0);

    bus1.sel = 2'd3;
    bus1.en  = 1'b0;
    bus8.sel = 2'd3;
    bus8.en  = 1'b0;
    #1;
    check("z1 immediate", 32'(bus1.z), 32'h1);
    check("z8 immediate", 32'(bus8.z), 32'hDD);
    tick();
    check("hold z_q1",   32'(bus1.z_q),   32'h0);
    check("hold sel_q1", 32'(bus1.sel_q), 32'h2);
    check("hold z_q8",   32'(bus8.z_q),   32'hBB);
    check("hold sel_q8", 32'(bus8.sel_q), 32'h1);
    chk_chg("hold chg", 1'b0);

    bus1.en = 1'b1;
    tick();
    check("en z_q1",   32'(bus1.z_q),   32'h1);
    check("en sel_q1", 32'(bus1.sel_q), 32'h3);
    chk_chg("rise chg", 1'b1);
    tick();
    check("reload z_q1", 32'(bus1.z_q), 32'h1);
    chk_chg("reload chg", 1'b0);

    rst = 1'b1;
    tick();
    check("mid rst z_q1",   32'(bus1.z_q),   32'h0);
    check("mid rst sel_q1", 32'(bus1.sel_q), 32'h0);
    check("mid rst z_q8",   32'(bus8.z_q),   32'h0);
    check("rst keeps z1",   32'(bus1.z),     32'h1);
    chk_chg("mid rst chg", 1'b0);

    rst = 1'b0;
    tick();
    check("post rst z_q1",   32'(bus1.z_q),   32'h1);
    check("post rst sel_q1", 32'(bus1.sel_q), 32'h3);
    chk_chg("post rst chg", 1'b1);

    bus1.en = 1'b0;
    tick();
    check("idle z_q1", 32'(bus1.z_q), 32'h1);
    chk_chg("idle chg", 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
